cpu_init_seq: RTL and testbench

CPU_INIT_SEQ -- requirements
Module: cpu_init_seq

---
 rtl/cpu_init_seq_pkg.sv | 31 +++
 rtl/init_hold_cnt.sv | 27 ++
 rtl/cpu_init_seq.sv | 165 ++++++++++++++++
 tb/tb_cpu_init_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_init_seq_pkg.sv
// Shared definitions for the CPU table-initialisation sequencer: FSM states,
// default table depths and output field widths.
package cpu_init_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LD_BTB = 3'd1,
      ST_LD_BHT = 3'd2,
      ST_LD_REG = 3'd3,
      ST_DONE   = 3'd4
   } init_state_e;

   localparam int DEF_HOLD_CYCLES = 2;
   localparam int DEF_BTB_DEPTH   = 256;
   localparam int DEF_BHT_DEPTH   = 256;
   localparam int DEF_REG_DEPTH   = 32;

   localparam int CFG_W  = 40;
   localparam int BTB_AW = 8;
   localparam int BTB_DW = 40;
   localparam int BHT_AW = 8;
   localparam int BHT_DW = 2;
   localparam int REG_AW = 5;
   localparam int REG_DW = 32;

   // Counter width that never collapses to zero bits (DEPTH=1 stays legal).
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/init_hold_cnt.sv
// Loadable down-counter that keeps each written table entry stable; saturates
// at zero and flags when it is there.
module init_hold_cnt #(
   parameter int W = 2
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/cpu_init_seq.sv
// Loads the CPU BTB, BHT and register file from a valid/ready config stream,
// holding each entry for HOLD_CYCLES, then releases the CPU via start.
module cpu_init_seq
   import cpu_init_seq_pkg::*;
#(
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int BTB_DEPTH   = DEF_BTB_DEPTH,
   parameter int BHT_DEPTH   = DEF_BHT_DEPTH,
   parameter int REG_DEPTH   = DEF_REG_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic              cfg_valid,
   input  logic [CFG_W-1:0]  cfg_data,
   output logic              cfg_ready,
   output logic [BTB_AW-1:0] btb_addr,
   output logic [BTB_DW-1:0] btb_init,
   output logic [BHT_AW-1:0] bht_addr,
   output logic [BHT_DW-1:0] bht_init,
   output logic [REG_AW-1:0] reg_addr,
   output logic [REG_DW-1:0] reg_init,
   output logic              init_mode,
   output logic              start,
   output init_state_e       o_dbg_state
);

   localparam int MAX_DEPTH = (BTB_DEPTH > BHT_DEPTH) ?
                              ((BTB_DEPTH > REG_DEPTH) ? BTB_DEPTH : REG_DEPTH) :
                              ((BHT_DEPTH > REG_DEPTH) ? BHT_DEPTH : REG_DEPTH);
   localparam int IW = clog2_min1(MAX_DEPTH);
   localparam int HW = clog2_min1(HOLD_CYCLES + 1);

   init_state_e       r_state;
   logic [IW-1:0]     r_idx;
   logic              r_last;
   logic [BTB_AW-1:0] r_btb_addr;
   logic [BTB_DW-1:0] r_btb_init;
   logic [BHT_AW-1:0] r_bht_addr;
   logic [BHT_DW-1:0] r_bht_init;
   logic [REG_AW-1:0] r_reg_addr;
   logic [REG_DW-1:0] r_reg_init;
   logic              r_init_mode;
   logic              r_start;

   logic              w_hold_zero;
   logic              w_loading;
   logic              w_ready;
   logic              w_xfer;
   logic [IW-1:0]     w_last_idx;
   logic              w_is_last;
   logic              w_advance;

   assign w_loading = (r_state == ST_LD_BTB) || (r_state == ST_LD_BHT) ||
                      (r_state == ST_LD_REG);
   // r_last blocks a further transfer while the final entry's hold drains.
   assign w_ready   = w_loading && w_hold_zero && !r_last;
   assign w_xfer    = cfg_valid && w_ready;
   assign w_advance = w_loading && r_last && w_hold_zero;

   always_comb begin
      w_last_idx = '0;
      case (r_state)
         ST_LD_BTB: w_last_idx = IW'(BTB_DEPTH - 1);
         ST_LD_BHT: w_last_idx = IW'(BHT_DEPTH - 1);
         ST_LD_REG: w_last_idx = IW'(REG_DEPTH - 1);
         default:   w_last_idx = '0;
      endcase
   end

   assign w_is_last = (r_idx == w_last_idx);

   init_hold_cnt #(
      .W (HW)
   ) u_hold (
      .i_clk      (clk),
      .i_rst_n    (rst),
      .i_load     (w_xfer),
      .i_load_val (HW'(HOLD_CYCLES)),
      .o_zero     (w_hold_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_last      <= 1'b0;
         r_btb_addr  <= '0;
         r_btb_init  <= '0;
         r_bht_addr  <= '0;
         r_bht_init  <= '0;
         r_reg_addr  <= '0;
         r_reg_init  <= '0;
         r_init_mode <= 1'b0;
         r_start     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (go) begin
                  r_state     <= ST_LD_BTB;
                  r_idx       <= '0;
                  r_last      <= 1'b0;
                  r_init_mode <= 1'b1;
                  r_start     <= 1'b0;
               end
            end
            ST_LD_BTB: begin
               if (w_xfer) begin
                  r_btb_addr <= BTB_AW'(r_idx);
                  r_btb_init <= cfg_data[BTB_DW-1:0];
                  r_idx      <= r_idx + IW'(1);
                  r_last     <= w_is_last;
               end else if (w_advance) begin
                  r_state <= ST_LD_BHT;
                  r_idx   <= '0;
                  r_last  <= 1'b0;
               end
            end
            ST_LD_BHT: begin
               if (w_xfer) begin
                  r_bht_addr <= BHT_AW'(r_idx);
                  r_bht_init <= cfg_data[BHT_DW-1:0];
                  r_idx      <= r_idx + IW'(1);
                  r_last     <= w_is_last;
               end else if (w_advance) begin
                  r_state <= ST_LD_REG;
                  r_idx   <= '0;
                  r_last  <= 1'b0;
               end
            end
            ST_LD_REG: begin
               if (w_xfer) begin
                  r_reg_addr <= REG_AW'(r_idx);
                  r_reg_init <= cfg_data[REG_DW-1:0];
                  r_idx      <= r_idx + IW'(1);
                  r_last     <= w_is_last;
               end else if (w_advance) begin
                  r_state     <= ST_DONE;
                  r_idx       <= '0;
                  r_last      <= 1'b0;
                  r_init_mode <= 1'b0;
                  r_start     <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_init_mode <= 1'b0;
               r_start     <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready   = w_ready;
   assign btb_addr    = r_btb_addr;
   assign btb_init    = r_btb_init;
   assign bht_addr    = r_bht_addr;
   assign bht_init    = r_bht_init;
   assign reg_addr    = r_reg_addr;
   assign reg_init    = r_reg_init;
   assign init_mode   = r_init_mode;
   assign start       = r_start;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cpu_init_seq.sv
// Bench for cpu_init_seq: a short directed vector table, then full load
// sequences checked entry by entry against a small output model.
module tb_cpu_init_seq;
   import cpu_init_seq_pkg::*;

   localparam int HOLD  = 2;
   localparam int NB    = 256;
   localparam int NH    = 256;
   localparam int NR    = 32;
   localparam int TOTAL = NB + NH + NR;

   logic        clk = 1'b0;
   logic        rst;
   logic        go;
   logic        cfg_valid;
   logic [39:0] cfg_data;
   logic        cfg_ready;
   logic [7:0]  btb_addr;
   logic [39:0] btb_init;
   logic [7:0]  bht_addr;
   logic [1:0]  bht_init;
   logic [4:0]  reg_addr;
   logic [31:0] reg_init;
   logic        init_mode;
   logic        start;
   init_state_e dbg_state;

   always #5 clk = ~clk;

   cpu_init_seq #(
      .HOLD_CYCLES (HOLD),
      .BTB_DEPTH   (NB),
      .BHT_DEPTH   (NH),
      .REG_DEPTH   (NR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .go          (go),
      .cfg_valid   (cfg_valid),
      .cfg_data    (cfg_data),
      .cfg_ready   (cfg_ready),
      .btb_addr    (btb_addr),
      .btb_init    (btb_init),
      .bht_addr    (bht_addr),
      .bht_init    (bht_init),
      .reg_addr    (reg_addr),
      .reg_init    (reg_init),
      .init_mode   (init_mode),
      .start       (start),
      .o_dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Expected table outputs
   logic [7:0]  m_btb_addr = '0;
   logic [39:0] m_btb_init = '0;
   logic [7:0]  m_bht_addr = '0;
   logic [1:0]  m_bht_init = '0;
   logic [4:0]  m_reg_addr = '0;
   logic [31:0] m_reg_init = '0;

   typedef struct {
      logic        rst_n;
      logic        go;
      logic        valid;
      logic [39:0] data;
      logic        e_rdy;
      logic        e_im;
      logic        e_st;
      logic [7:0]  e_ba;
      logic [39:0] e_bi;
   } vec_t;

   vec_t vecs[14];

   function automatic logic [97:0] pack(input logic rdy, input logic im, input logic st,
                                        input logic [7:0] ba, input logic [39:0] bi,
                                        input logic [7:0] ha, input logic [1:0] hi,
                                        input logic [4:0] ra, input logic [31:0] ri);
      return {rdy, im, st, ba, bi, ha, hi, ra, ri};
   endfunction

   function automatic logic [97:0] dut_tuple();
      return pack(cfg_ready, init_mode, start, btb_addr, btb_init,
                  bht_addr, bht_init, reg_addr, reg_init);
   endfunction

   function automatic logic [39:0] data_for(input int k);
      if (k % 7 == 3) return 40'hFF_FFFF_FFFF;
      return {8'(k) ^ 8'hC3, 32'(k)};
   endfunction

   task automatic chk(input string name, input logic [97:0] act, input logic [97:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chk_model(input string name, input logic rdy, input logic im, input logic st);
      chk(name, dut_tuple(), pack(rdy, im, st, m_btb_addr, m_btb_init,
                                  m_bht_addr, m_bht_init, m_reg_addr, m_reg_init));
   endtask

   task automatic model_zero();
      m_btb_addr = '0; m_btb_init = '0;
      m_bht_addr = '0; m_bht_init = '0;
      m_reg_addr = '0; m_reg_init = '0;
   endtask

   task automatic pulse_go();
      @(negedge clk);
      go = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
   endtask

   // Feeds transfers until stop_k have been accepted; checks every accepted
   // entry, spacing between transfers and, for a full load, the DONE entry.
   task automatic run_load(input bit rnd, input int stop_k, input bit go_in_reg);
      int k = 0;
      int cyc = 0;
      int last_cyc = -1;
      int prev_tbl = -1;
      int gap_bad = 0;
      int tbl;
      int gap;
      int n;
      bit acc;
      bit go_sent = 1'b0;
      logic [39:0] d;
      while (k < stop_k && cyc < 20000) begin
         @(negedge clk);
         go = 1'b0;
         if (go_in_reg && !go_sent && k == NB + NH + 8) begin
            go = 1'b1;
            go_sent = 1'b1;
         end
         cfg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         d = data_for(k);
         cfg_data = cfg_valid ? d : 40'({$urandom(), $urandom()});
         acc = cfg_valid && cfg_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            tbl = (k < NB) ? 0 : (k < NB + NH) ? 1 : 2;
            case (tbl)
               0: begin m_btb_addr = 8'(k);           m_btb_init = d;       end
               1: begin m_bht_addr = 8'(k - NB);      m_bht_init = d[1:0];  end
               default: begin m_reg_addr = 5'(k - NB - NH); m_reg_init = d[31:0]; end
            endcase
            chk_model($sformatf("xfer%0d", k), 1'b0, 1'b1, 1'b0);
            if (last_cyc >= 0) begin
               gap = cyc - last_cyc;
               if (rnd) begin
                  if (gap < HOLD + 1) gap_bad++;
               end else if (gap != ((tbl != prev_tbl) ? HOLD + 2 : HOLD + 1)) begin
                  gap_bad++;
               end
            end
            last_cyc = cyc;
            prev_tbl = tbl;
            k++;
         end
      end
      go = 1'b0;
      chk_int("xfer_count", k, stop_k);
      chk_int("xfer_gap_errors", gap_bad, 0);
      if (stop_k == TOTAL) begin
         // valid stays high so a transfer past the last entry would show up
         cfg_valid = 1'b1;
         cfg_data  = 40'h55_AAAA_5555;
         n = 0;
         while (start !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
         end
         chk_int("done_latency", n, HOLD + 1);
         chk_model("done_outputs", 1'b0, 1'b0, 1'b1);
      end
      cfg_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      go = 1'b0;
      cfg_valid = 1'b0;
      cfg_data = '0;

      //          rst go v  data                rdy im st ba     bi
      vecs[0]  = '{0, 0, 0, 40'h0,              0, 0, 0, 8'd0, 40'h0};
      vecs[1]  = '{1, 0, 0, 40'h0,              0, 0, 0, 8'd0, 40'h0};
      vecs[2]  = '{1, 0, 1, 40'hAA,             0, 0, 0, 8'd0, 40'h0};
      vecs[3]  = '{1, 1, 0, 40'h0,              1, 1, 0, 8'd0, 40'h0};
      vecs[4]  = '{1, 0, 0, 40'h77,             1, 1, 0, 8'd0, 40'h0};
      vecs[5]  = '{1, 0, 0, 40'h0,              1, 1, 0, 8'd0, 40'h0};
      vecs[6]  = '{1, 0, 1, 40'h12_3456_789A,   0, 1, 0, 8'd0, 40'h12_3456_789A};
      vecs[7]  = '{1, 0, 1, 40'h11_1111_1111,   0, 1, 0, 8'd0, 40'h12_3456_789A};
      vecs[8]  = '{1, 0, 1, 40'h22_2222_2222,   1, 1, 0, 8'd0, 40'h12_3456_789A};
      vecs[9]  = '{1, 0, 1, 40'hAB_CDEF_0123,   0, 1, 0, 8'd1, 40'hAB_CDEF_0123};
      vecs[10] = '{1, 1, 0, 40'h0,              0, 1, 0, 8'd1, 40'hAB_CDEF_0123};
      vecs[11] = '{1, 0, 0, 40'h0,              1, 1, 0, 8'd1, 40'hAB_CDEF_0123};
      vecs[12] = '{0, 0, 1, 40'h33,             0, 0, 0, 8'd0, 40'h0};
      vecs[13] = '{1, 0, 0, 40'h0,              0, 0, 0, 8'd0, 40'h0};

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         rst       = vecs[i].rst_n;
         go        = vecs[i].go;
         cfg_valid = vecs[i].valid;
         cfg_data  = vecs[i].data;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d", i), dut_tuple(),
             pack(vecs[i].e_rdy, vecs[i].e_im, vecs[i].e_st, vecs[i].e_ba, vecs[i].e_bi,
                  8'd0, 2'd0, 5'd0, 32'd0));
      end
      go = 1'b0;
      cfg_valid = 1'b0;
      model_zero();

      // Full load with valid held high, stray go while loading REG
      pulse_go();
      chk_model("go_from_idle", 1'b1, 1'b1, 1'b0);
      run_load(1'b0, TOTAL, 1'b1);

      // Restart from DONE: tables keep their last values
      pulse_go();
      chk_model("go_from_done", 1'b1, 1'b1, 1'b0);

      // Reset just after BHT entry 100 is written
      run_load(1'b0, NB + 101, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      cfg_valid = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      cfg_valid = 1'b0;
      model_zero();
      chk_model("mid_load_reset", 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk_model("idle_after_reset", 1'b0, 1'b0, 1'b0);

      // Fresh load from BTB entry 0 with a randomly stalling source
      pulse_go();
      chk_model("go_after_reset", 1'b1, 1'b1, 1'b0);
      run_load(1'b1, TOTAL, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
